// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared definitions for the decode-stage issue scoreboard (former mycpu.vh contents).
package id_scoreboard_ctrl_pkg;

  localparam int unsigned GPR_AW    = 5;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 2;

  // Writeback-to-regfile bus layout: {rf_we, rf_waddr, rf_wdata}
  localparam int unsigned WS_RF_BUS_W     = 38;
  localparam int unsigned WS_RF_WE_BIT    = 37;
  localparam int unsigned WS_RF_WADDR_MSB = 36;
  localparam int unsigned WS_RF_WADDR_LSB = 32;

  typedef logic [GPR_AW-1:0] gpr_addr_t;

  function automatic logic gpr_tracked(input gpr_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/id_sb_entry.sv
// One scoreboard entry: saturating pending-write counter for a single GPR.
module id_sb_entry #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic issue_hit,
  input  logic retire_hit,
  input  logic flush,
  output logic busy,
  output logic full
);

  logic [CNT_W-1:0] cnt;

  assign busy = |cnt;
  assign full = &cnt;

  // Simultaneous issue and retire cancel; neither end wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (issue_hit && !retire_hit && !full) begin
      cnt <= cnt + 1'b1;
    end else if (retire_hit && !issue_hit && busy) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage issue controller: per-GPR pending-write scoreboard and ready-go.
// Optional stall statistics counter enabled by ID_SB_STALL_STATS_EN.
module id_scoreboard_ctrl
  import id_scoreboard_ctrl_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ds_valid,
  input  logic [GPR_AW-1:0] rs1_addr,
  input  logic              rs1_used,
  input  logic [GPR_AW-1:0] rs2_addr,
  input  logic              rs2_used,
  input  logic [GPR_AW-1:0] dest,
  input  logic              gr_we,
  input  logic              es_allowin,
  input  logic              ws_rf_we,
  input  logic [GPR_AW-1:0] ws_rf_waddr,
  input  logic              flush,
  output logic              ds_ready_go,
  output logic [NREG-1:0]   sb_busy,
  output logic [31:0]       stall_cnt
);

  logic [NREG-1:0] busy_vec;
  logic [NREG-1:0] full_vec;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            waw_full;
  logic            issue;
  logic            retire;

  assign busy_vec[0] = 1'b0;
  assign full_vec[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_entry
      id_sb_entry #(
        .CNT_W (CNT_W)
      ) u_entry (
        .clk        (clk),
        .resetn     (resetn),
        .issue_hit  (issue && (dest == GPR_AW'(g))),
        .retire_hit (retire && (ws_rf_waddr == GPR_AW'(g))),
        .flush      (flush),
        .busy       (busy_vec[g]),
        .full       (full_vec[g])
      );
    end
  endgenerate

  assign rs1_hazard  = rs1_used && gpr_tracked(rs1_addr) && busy_vec[rs1_addr];
  assign rs2_hazard  = rs2_used && gpr_tracked(rs2_addr) && busy_vec[rs2_addr];
  assign waw_full    = gr_we && gpr_tracked(dest) && full_vec[dest];
  assign ds_ready_go = !(rs1_hazard || rs2_hazard || waw_full);

  assign issue  = ds_valid && ds_ready_go && es_allowin && gr_we && gpr_tracked(dest);
  assign retire = ws_rf_we && gpr_tracked(ws_rf_waddr);

  assign sb_busy = busy_vec;

`ifdef ID_SB_STALL_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Directed self-checking bench for id_scoreboard_ctrl.
module tb_id_scoreboard_ctrl;

  logic        clk;
  logic        resetn;
  logic        ds_valid;
  logic [4:0]  rs1_addr;
  logic        rs1_used;
  logic [4:0]  rs2_addr;
  logic        rs2_used;
  logic [4:0]  dest;
  logic        gr_we;
  logic        es_allowin;
  logic        ws_rf_we;
  logic [4:0]  ws_rf_waddr;
  logic        flush;
  logic        ds_ready_go;
  logic [31:0] sb_busy;
  logic [31:0] stall_cnt;

  int checks;
  int errors;

  id_scoreboard_ctrl #(
    .NREG  (32),
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ds_valid    (ds_valid),
    .rs1_addr    (rs1_addr),
    .rs1_used    (rs1_used),
    .rs2_addr    (rs2_addr),
    .rs2_used    (rs2_used),
    .dest        (dest),
    .gr_we       (gr_we),
    .es_allowin  (es_allowin),
    .ws_rf_we    (ws_rf_we),
    .ws_rf_waddr (ws_rf_waddr),
    .flush       (flush),
    .ds_ready_go (ds_ready_go),
    .sb_busy     (sb_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    ds_valid = 0; rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0;
    dest = 0; gr_we = 0; es_allowin = 1; ws_rf_we = 0; ws_rf_waddr = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d);
    clr(); ds_valid = 1; gr_we = 1; dest = d;
    step();
  endtask

  task automatic retire(input logic [4:0] d);
    clr(); ws_rf_we = 1; ws_rf_waddr = d;
    step();
  endtask

  task automatic pulse_reset();
    clr();
    resetn = 0;
    #2;
    resetn = 1;
    step();
  endtask

  task automatic test_reset();
    clr();
    resetn = 0;
    #7;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL reset_ready_go: got %b want 1", ds_ready_go); end
    checks++;
    if (sb_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", sb_busy); end
    checks++;
    if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    resetn = 1;
    step();
  endtask

  task automatic test_midrun_reset();
    issue(5'd5);
    issue(5'd5);
    checks++;
    if (sb_busy !== 32'h0000_0020) begin errors++; $display("FAIL midreset_pre_busy: got %h want 00000020", sb_busy); end
    clr(); ds_valid = 1; rs1_used = 1; rs1_addr = 5'd5;
    resetn = 0;
    #1;
    checks++;
    if (sb_busy !== 32'h0) begin errors++; $display("FAIL midreset_busy: got %h want 0", sb_busy); end
    checks++;
    if (stall_cnt !== 32'h0) begin errors++; $display("FAIL midreset_stall_cnt: got %0d want 0", stall_cnt); end
    resetn = 1;
    #1;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL midreset_rs1_go: got %b want 1", ds_ready_go); end
    step();
  endtask

  task automatic test_raw_stall();
    issue(5'd3);
    for (int c = 1; c <= 4; c++) begin
      clr(); ds_valid = 1; rs1_used = 1; rs1_addr = 5'd3; dest = 5'd8;
      if (c == 4) begin ws_rf_we = 1; ws_rf_waddr = 5'd3; end
      #1;
      checks++;
      if (ds_ready_go !== 1'b0) begin errors++; $display("FAIL raw_go_c%0d: got %b want 0", c, ds_ready_go); end
      checks++;
      if (sb_busy[3] !== 1'b1) begin errors++; $display("FAIL raw_busy_c%0d: got %b want 1", c, sb_busy[3]); end
      step();
    end
    clr(); ds_valid = 1; rs1_used = 1; rs1_addr = 5'd3; dest = 5'd8;
    #1;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL raw_go_c5: got %b want 1", ds_ready_go); end
    checks++;
    if (sb_busy[3] !== 1'b0) begin errors++; $display("FAIL raw_busy_c5: got %b want 0", sb_busy[3]); end
    step();
  endtask

  task automatic test_same_reg_issue_retire();
    issue(5'd7);
    clr(); ds_valid = 1; gr_we = 1; dest = 5'd7; ws_rf_we = 1; ws_rf_waddr = 5'd7;
    step();
    checks++;
    if (sb_busy !== 32'h0000_0080) begin errors++; $display("FAIL same_reg_busy: got %h want 00000080", sb_busy); end
    retire(5'd7);
    checks++;
    if (sb_busy[7] !== 1'b0) begin errors++; $display("FAIL same_reg_drain: got %b want 0", sb_busy[7]); end
  endtask

  task automatic test_diff_reg_issue_retire();
    issue(5'd12);
    clr(); ds_valid = 1; gr_we = 1; dest = 5'd13; ws_rf_we = 1; ws_rf_waddr = 5'd12;
    step();
    checks++;
    if (sb_busy !== 32'h0000_2000) begin errors++; $display("FAIL diff_reg_busy: got %h want 00002000", sb_busy); end
    retire(5'd13);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      clr(); ds_valid = 1; gr_we = 1; dest = 5'd9;
      #1;
      checks++;
      if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL b2b_go_%0d: got %b want 1", k, ds_ready_go); end
      step();
    end
    clr(); ds_valid = 1; gr_we = 1; dest = 5'd9;
    #1;
    checks++;
    if (ds_ready_go !== 1'b0) begin errors++; $display("FAIL b2b_waw_full: got %b want 0", ds_ready_go); end
    step();
    ws_rf_we = 1; ws_rf_waddr = 5'd9;
    #1;
    checks++;
    if (ds_ready_go !== 1'b0) begin errors++; $display("FAIL b2b_waw_retire_cycle: got %b want 0", ds_ready_go); end
    step();
    ws_rf_we = 0;
    #1;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL b2b_waw_release: got %b want 1", ds_ready_go); end
    step();
    retire(5'd9);
    retire(5'd9);
    checks++;
    if (sb_busy[9] !== 1'b1) begin errors++; $display("FAIL b2b_two_drained: got %b want 1", sb_busy[9]); end
    retire(5'd9);
    checks++;
    if (sb_busy[9] !== 1'b0) begin errors++; $display("FAIL b2b_three_drained: got %b want 0", sb_busy[9]); end
  endtask

  task automatic test_flush();
    issue(5'd2);
    issue(5'd4);
    issue(5'd4);
    checks++;
    if (sb_busy !== 32'h0000_0014) begin errors++; $display("FAIL flush_pre_busy: got %h want 00000014", sb_busy); end
    clr(); ds_valid = 1; gr_we = 1; dest = 5'd6; ws_rf_we = 1; ws_rf_waddr = 5'd4; flush = 1;
    step();
    clr();
    checks++;
    if (sb_busy !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h want 0", sb_busy); end
    ds_valid = 1; rs1_used = 1; rs1_addr = 5'd4; rs2_used = 1; rs2_addr = 5'd6;
    #1;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL flush_go: got %b want 1", ds_ready_go); end
    step();
  endtask

  task automatic test_reg_zero();
    clr(); ds_valid = 1; rs1_used = 1; rs2_used = 1; gr_we = 1;
    #1;
    checks++;
    if (ds_ready_go !== 1'b1) begin errors++; $display("FAIL zero_go: got %b want 1", ds_ready_go); end
    step();
    step();
    checks++;
    if (sb_busy !== 32'h0) begin errors++; $display("FAIL zero_busy: got %h want 0", sb_busy); end
  endtask

  task automatic test_stall_stats();
    logic [31:0] exp_cnt;
    pulse_reset();
    issue(5'd10);
    clr(); ds_valid = 1; rs2_used = 1; rs2_addr = 5'd10;
    repeat (10) step();
    clr(); rs1_used = 1; rs1_addr = 5'd10;
    repeat (3) step();
`ifdef ID_SB_STALL_STATS_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stats_count: got %0d want %0d", stall_cnt, exp_cnt); end
    clr(); flush = 1;
    step();
    clr();
    checks++;
    if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stats_after_flush: got %0d want %0d", stall_cnt, exp_cnt); end
    checks++;
    if (sb_busy !== 32'h0) begin errors++; $display("FAIL stats_flush_busy: got %h want 0", sb_busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    resetn = 1;
    test_reset();
    test_midrun_reset();
    test_raw_stall();
    test_same_reg_issue_retire();
    test_diff_reg_issue_retire();
    test_back_to_back();
    test_flush();
    test_reg_zero();
    test_stall_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- Issue controller for the decode stage's register file read ports.
- Tracks in-flight GPR writes (decode issued, writeback not yet done) in a per-register pending-count scoreboard.
- Generates the decode stage's ready-go signal: a decoded instruction leaves decode only when none of its source registers has a pending write.
- Sits beside the decode stage; takes decoded source/destination fields from it and retire information from the writeback-to-regfile bus.

Parameters:
- NREG, 32, number of architectural GPRs tracked (entry 0 is hardwired, never tracked).
- CNT_W, 2, width of each pending counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_valid  in  1  decode stage holds a valid instruction
- rs1_addr  in  5  first source register (rj)
- rs1_used  in  1  instruction reads rs1
- rs2_addr  in  5  second source register (rk or rd, as selected by the decode stage)
- rs2_used  in  1  instruction reads rs2
- dest  in  5  destination register
- gr_we  in  1  instruction writes a GPR
- es_allowin  in  1  execute stage can accept
- ws_rf_we  in  1  writeback writes the regfile this cycle
- ws_rf_waddr  in  5  writeback destination
- flush  in  1  cancel all instructions in execute, memory and writeback
- ds_ready_go  out  1  decode may hand off
- sb_busy  out  NREG  bitmap, bit i = counter i nonzero
- stall_cnt  out  32  count of decode stall cycles (feature-dependent)

Behaviour:
- Reset (async, resetn=0):
  - all counters = 0
  - sb_busy = 0
  - stall_cnt = 0
  - ds_ready_go = 1 (combinational from cleared state)
- hazard (combinational from registered counters):
  - rs1 term: rs1_used & rs1_addr!=0 & cnt[rs1_addr]!=0
  - rs2 term: rs2_used & rs2_addr!=0 & cnt[rs2_addr]!=0
  - hazard = rs1 term | rs2 term
- waw_full = gr_we & dest!=0 & cnt[dest]==max (all ones).
- ds_ready_go = ~(hazard | waw_full).
  - Output is independent of ds_valid; invalid cycles are masked by the fire term.
- issue = ds_valid & ds_ready_go & es_allowin & gr_we & dest!=0. On issue, cnt[dest] +1.
- retire = ws_rf_we & ws_rf_waddr!=0. On retire, cnt[ws_rf_waddr] -1.
- Same register, issue and retire in the same cycle: counter unchanged.
- Different registers: both updates apply.
- No same-cycle bypass. A retire in cycle N clears a hazard only from cycle N+1, because the regfile write lands at the edge.
- Retire on a zero counter is illegal: the counter holds 0 (no wrap). Verification asserts it never happens.
- flush=1: all counters cleared next edge. Flush wins over any issue or retire in the same cycle. The pipeline guarantees no retire of cancelled instructions afterwards.
- Register 0: never stalls, never counted. sb_busy[0] always 0.
- Counter state transitions per entry:
  - IDLE(0) -> PEND(n>0) on issue.
  - PEND(n) -> PEND(n±1) on issue/retire.
  - PEND(1) -> IDLE on retire.
  - Any -> IDLE on flush or reset.
- sb_busy: registered-state view, valid the cycle after the update edge.

Optional Feature:
- Macro: ID_SB_STALL_STATS_EN
- Defined:
  - stall_cnt increments by 1 each cycle ds_valid & ~ds_ready_go.
  - Wraps at 2^32.
  - Cleared only by reset; flush does not clear it.
- Undefined:
  - no counter register is built.
  - stall_cnt is tied to 0.

Decomposition:
- Existing shared header (mycpu.vh):
  - GPR address width
  - NREG default
  - CNT_W default
  - field positions of the writeback-to-regfile bus, used by the parent to extract ws_rf_we/ws_rf_waddr
- One sub-module: id_sb_entry.
  - Contents: a single saturating up/down counter with issue_hit, retire_hit and flush inputs, plus a busy output.
  - Instantiated NREG-1 times via generate.

Test Plan:
1. Reset with resetn=0 mid-run while cnt[5]=2 -> cnt, sb_busy=0 and stall_cnt=0 immediately. After resetn=1, an instruction with rs1=5 gets ds_ready_go=1.
2. RAW stall:
   - Issue dest=3 at cycle 0.
   - Next instruction rs1=3 -> ds_ready_go=0 until ws_rf_we with waddr=3 in cycle 4.
   - ds_ready_go=1 in cycle 5; sb_busy[3] = 1 in cycles 1–4, 0 from cycle 5.
3. Issue and retire of reg 7 in the same cycle with cnt[7]=1 -> cnt[7] stays 1, sb_busy[7]=1.
4. Three back-to-back issues to dest=9 -> cnt=3. A fourth writer to 9 gets ds_ready_go=0 (waw_full) until one retire.
5. flush with cnt[2]=1, cnt[4]=2, plus simultaneous issue to 6 -> all counters 0 next cycle, sb_busy=0.
6. rs1=0, rs2=0 and dest=0 with gr_we=1 -> no stall and no counter change. With ID_SB_STALL_STATS_EN, 10 stalled valid cycles -> stall_cnt=10.
